// File: rtl/counter_sched_pkg.sv
// Shared definitions for the round-robin counter scheduler: state codes,
// default counter width and the circular request picker.
package counter_sched_pkg;

  localparam int CNT_W   = 4;
  localparam int MAX_REQ = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t RUN    = 2'd1;
  localparam state_t FINISH = 2'd2;

  // First set bit at or after ptr, wrapping within the low n bits of req.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input logic [3:0] n);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = 3'd0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % int'(n);
      if (!found && (i < int'(n)) && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end else begin
        pick  = pick;
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational winner search from a registered pointer
// that moves to just past the owner whenever a run ends.
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [IDXW-1:0]    adv_idx,
  output logic               any,
  output logic [IDXW-1:0]    pick
);

  logic [IDXW-1:0] ptr;
  logic [2:0]      pick_wide;

  // Winner search over the live request vector.
  always_comb begin
    pick_wide = rr_pick(8'(req), 3'(ptr), 4'(NUM_REQ));
    pick      = pick_wide[IDXW-1:0];
    any       = |req;
  end

  // Pointer update, applied on the cycle the run ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= {IDXW{1'b0}};
    end else if (advance) begin
      if (adv_idx == IDXW'(NUM_REQ - 1)) begin
        ptr <= {IDXW{1'b0}};
      end else begin
        ptr <= adv_idx + IDXW'(1'b1);
      end
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Shares one up-counter between NUM_REQ timer clients. Each grant runs the
// counter from 0 to the owner's latched terminal count, then pulses done.
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = CNT_W,
  localparam int IDXW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] term_cnt,
  output logic [NUM_REQ-1:0]       grant,
  output logic [WIDTH-1:0]         counter_out,
  output logic                     overflow_out,
  output logic                     done,
  output logic                     abort,
  output logic [IDXW-1:0]          done_id
);

  state_t             state;
  logic [IDXW-1:0]    owner;
  logic [WIDTH-1:0]   tc;
  logic               owner_req;
  logic               at_tc;
  logic               cnt_en;
  logic               cnt_clr;
  logic               finish_run;
  logic               arb_any;
  logic [IDXW-1:0]    arb_pick;
  logic [NUM_REQ-1:0] pick_onehot;

  // Run-control decode shared by the counter, flag and FSM.
  always_comb begin
    owner_req   = req[owner];
    at_tc       = (counter_out == tc);
    cnt_en      = (state == RUN) && owner_req && !at_tc;
    cnt_clr     = (state != RUN) || !owner_req;
    finish_run  = (state == RUN) && (!owner_req || at_tc);
    pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_pick;
  end

  // The FINISH cycle may arbitrate too, so the pointer must already be past
  // the old owner when the run ends.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (finish_run),
    .adv_idx (owner),
    .any     (arb_any),
    .pick    (arb_pick)
  );

  // Shared counter datapath: counts only while the owner's run is live.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      counter_out <= {WIDTH{1'b0}};
    end else if (cnt_en) begin
      counter_out <= counter_out + WIDTH'(1'b1);
    end else begin
      counter_out <= counter_out;
    end
  end

  // Sticky overflow: cleared when a new grant is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_out <= 1'b0;
    end else if ((state != RUN) && arb_any) begin
      overflow_out <= 1'b0;
    end else if ((state == RUN) && (counter_out == {WIDTH{1'b1}})) begin
      overflow_out <= 1'b1;
    end else begin
      overflow_out <= overflow_out;
    end
  end

  // Scheduler FSM with registered grant and completion pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= {IDXW{1'b0}};
      tc      <= {WIDTH{1'b0}};
      grant   <= {NUM_REQ{1'b0}};
      done    <= 1'b0;
      abort   <= 1'b0;
      done_id <= {IDXW{1'b0}};
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      case (state)
        IDLE, FINISH: begin
          if (arb_any) begin
            state <= RUN;
            owner <= arb_pick;
            tc    <= term_cnt[arb_pick*WIDTH +: WIDTH];
            grant <= pick_onehot;
          end else begin
            state <= IDLE;
            grant <= {NUM_REQ{1'b0}};
          end
        end
        RUN: begin
          if (!owner_req) begin
            abort   <= 1'b1;
            done_id <= owner;
            grant   <= {NUM_REQ{1'b0}};
            state   <= IDLE;
          end else if (at_tc) begin
            done    <= 1'b1;
            done_id <= owner;
            grant   <= {NUM_REQ{1'b0}};
            state   <= FINISH;
          end else begin
            state   <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          grant <= {NUM_REQ{1'b0}};
        end
      endcase
    end
  end

endmodule
